// File: rtl/led_pattern_shifter_if.sv
// Control/pattern bundle between the board-side driver and the
// LED pattern engine.
interface led_pattern_shifter_if #(
  parameter int N_LEDS = 25
);
  logic              button;
  logic [1:0]        mode;
  logic              pause;
  logic              clear;
  logic [N_LEDS-1:0] R;
  logic [N_LEDS-1:0] G;
  logic [N_LEDS-1:0] B;
  logic [1:0]        status_leds;
  logic              tick;

  modport master (
    output button, mode, pause, clear,
    input  R, G, B, status_leds, tick
  );

  modport slave (
    input  button, mode, pause, clear,
    output R, G, B, status_leds, tick
  );
endinterface

// File: rtl/led_pattern_shifter.sv
// RGB LED pattern engine: debounced button, prescaled step tick and
// a 3*N_LEDS-bit chain stepped by fill/rotate/bounce/freeze modes.
module led_pattern_shifter #(
  parameter int N_LEDS     = 25,
  parameter int TICK_DIV   = 2097152,
  parameter int DEB_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pattern_shifter_if.slave  bus
);

  localparam int K  = 3 * N_LEDS;
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(K);

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BNC_LAST = BW'(K - 2);
  localparam logic [K-1:0]  INIT     = {{(K-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    M_FILL = 2'b00,
    M_ROT  = 2'b01,
    M_BNC  = 2'b10,
    M_FRZ  = 2'b11
  } mode_e;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_btn_db;
  logic [DW-1:0] r_deb_cnt;
  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [K-1:0]  r_chain;
  logic          r_dir;
  logic [BW-1:0] r_bnc;
  mode_e         r_mode_q;

  logic          w_step;
  mode_e         w_mode;
  logic          w_enter_bnc;
  logic          w_dir;
  logic [BW-1:0] w_bnc;
  logic [K-1:0]  w_rol;
  logic [K-1:0]  w_ror;
  logic [K-1:0]  w_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  // Counter only advances while the synced level disagrees with btn_db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_db  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_btn_db) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_LAST) begin
      r_btn_db  <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  assign w_step = !bus.pause && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (bus.pause) begin
      r_tick <= 1'b0;
    end else if (w_step) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign w_mode      = mode_e'(bus.mode);
  assign w_enter_bnc = (w_mode == M_BNC) && (r_mode_q != M_BNC);
  assign w_dir       = w_enter_bnc ? 1'b0 : r_dir;
  assign w_bnc       = w_enter_bnc ? '0 : r_bnc;
  assign w_rol       = {r_chain[K-2:0], r_chain[K-1]};
  assign w_ror       = {r_chain[0], r_chain[K-1:1]};
  assign w_fill      = {r_chain[K-2:0], r_btn_db};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= M_FILL;
    end else if (w_step) begin
      r_mode_q <= w_mode;
    end
  end

  // clear beats a coincident step; dir 0 = left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= INIT;
      r_dir   <= 1'b0;
      r_bnc   <= '0;
    end else if (bus.clear) begin
      r_chain <= INIT;
      r_dir   <= 1'b0;
      r_bnc   <= '0;
    end else if (w_step) begin
      unique case (w_mode)
        M_FILL: r_chain <= w_fill;
        M_ROT:  r_chain <= w_rol;
        M_BNC: begin
          r_chain <= w_dir ? w_ror : w_rol;
          if (w_bnc == BNC_LAST) begin
            r_dir <= ~w_dir;
            r_bnc <= '0;
          end else begin
            r_dir <= w_dir;
            r_bnc <= w_bnc + 1'b1;
          end
        end
        M_FRZ:  r_chain <= r_chain;
      endcase
    end
  end

  assign bus.R           = r_chain[N_LEDS-1:0];
  assign bus.G           = r_chain[2*N_LEDS-1:N_LEDS];
  assign bus.B           = r_chain[K-1:2*N_LEDS];
  assign bus.status_leds = {~r_btn_db, r_btn_db};
  assign bus.tick        = r_tick;

endmodule
